// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, state encodings and character map for the LCD value display
// Contents: HD44780 command bytes, top/byte-writer state enums, val_to_char().
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] CMD_LINE2    = 8'hC0;  // DDRAM address 0x40
    localparam logic [7:0] CMD_SHIFT_L  = 8'h18;
    localparam logic [7:0] CMD_SHIFT_R  = 8'h1C;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_LINE2,
        ST_SHIFT,
        ST_FIN
    } lcd_state_e;

    typedef enum logic [2:0] {
        W_IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        W_WAIT
    } wr_state_e;

    // 0..9 -> '0'..'9', 10..31 -> 'A'..'V'
    function automatic logic [7:0] val_to_char(input logic [4:0] v);
        if (v < 5'd10) begin
            return 8'h30 + {3'b000, v};
        end
        return 8'h41 + {3'b000, v} - 8'd10;
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// rtl/lcd_byte_writer.sv - one LCD bus byte: SETUP, E pulse, HOLD, settle wait
// Ports: clk, rst (async active-low); req/rs/data/long_wait request a byte,
//        ack pulses in the last busy cycle; lcd_rs/lcd_e/lcd_db drive the bus.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int EN_CYC  = 12,
    parameter int CMD_CYC = 2000,
    parameter int CLR_CYC = 82000,
    parameter int CNT_W   = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       ack,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

    // The accepting IDLE cycle is counted as the final settle cycle, so WAIT
    // itself lasts one cycle less and back-to-back bytes have no extra gap.
    localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_CYC - 2);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 2);

    wr_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             long_q;
    logic             rs_q;
    logic             e_q;
    logic [7:0]       db_q;
    logic [CNT_W-1:0] wait_last;

    assign wait_last = long_q ? CLR_LAST : CMD_LAST;
    assign ack       = (state_q == W_WAIT) && (cnt_q == wait_last);

    assign lcd_rs = rs_q;
    assign lcd_e  = e_q;
    assign lcd_db = db_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= W_IDLE;
            cnt_q   <= '0;
            long_q  <= 1'b0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            db_q    <= 8'h00;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (req) begin
                        rs_q    <= rs;
                        db_q    <= data;
                        long_q  <= long_wait;
                        state_q <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    e_q     <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= W_PULSE;
                end
                W_PULSE: begin
                    if (cnt_q == EN_LAST) begin
                        e_q     <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= W_HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                W_HOLD: begin
                    cnt_q   <= '0;
                    state_q <= W_WAIT;
                end
                W_WAIT: begin
                    if (cnt_q == wait_last) begin
                        state_q <= W_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_value_display.sv
// rtl/lcd_value_display.sv - HD44780 init, value-to-ASCII update and display shift sequencer
// Ports: clk, rst (async active-low); start/values request an update, shift_req/shift_dir
//        request a shift; ready/done status; RS/RW/E/DB drive the LCD bus (write only).
module lcd_value_display
    import lcd_pkg::*;
#(
    parameter int NUM_VALUES = 10,
    parameter int VAL_W      = 5,
    parameter int LINE_LEN   = 16,
    parameter int PWRUP_CYC  = 750000,
    parameter int EN_CYC     = 12,
    parameter int CMD_CYC    = 2000,
    parameter int CLR_CYC    = 82000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_VALUES*VAL_W-1:0] values,
    input  logic                        shift_req,
    input  logic                        shift_dir,
    output logic                        ready,
    output logic                        done,
    output logic                        RS,
    output logic                        RW,
    output logic                        E,
    output logic [7:0]                  DB
);

    localparam int MAX_A   = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
    localparam int MAX_B   = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int IDX_W   = $clog2(NUM_VALUES + 1);

    lcd_state_e                  state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [1:0]                  init_idx_q;
    logic [IDX_W-1:0]            idx_q;
    logic [IDX_W-1:0]            idx_d;
    logic [NUM_VALUES*VAL_W-1:0] snap_q;
    logic                        dir_q;
    logic                        ready_q;
    logic                        done_q;

    logic       wr_req;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_long;
    logic       wr_ack;
    logic [4:0] cur_val;

    assign idx_d = idx_q + IDX_W'(1);

    // Byte to present is a pure function of the current state; the writer only
    // samples it while idle, so holding req high during a byte is harmless.
    always_comb begin
        wr_req  = 1'b0;
        wr_rs   = 1'b0;
        wr_data = 8'h00;
        cur_val = '0;
        for (int i = 0; i < NUM_VALUES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_val = 5'(snap_q[i*VAL_W +: VAL_W]);
            end
        end
        case (state_q)
            ST_INIT: begin
                wr_req = 1'b1;
                case (init_idx_q)
                    2'd0:    wr_data = CMD_FUNC_SET;
                    2'd1:    wr_data = CMD_DISP_ON;
                    2'd2:    wr_data = CMD_ENTRY;
                    default: wr_data = CMD_CLEAR;
                endcase
            end
            ST_ADDR: begin
                wr_req  = 1'b1;
                wr_data = CMD_LINE1;
            end
            ST_DATA: begin
                wr_req  = 1'b1;
                wr_rs   = 1'b1;
                wr_data = val_to_char(cur_val);
            end
            ST_LINE2: begin
                wr_req  = 1'b1;
                wr_data = CMD_LINE2;
            end
            ST_SHIFT: begin
                wr_req  = 1'b1;
                wr_data = dir_q ? CMD_SHIFT_R : CMD_SHIFT_L;
            end
            default: begin
                wr_req = 1'b0;
            end
        endcase
        wr_long = !wr_rs && (wr_data == CMD_CLEAR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_PWRUP;
            cnt_q      <= '0;
            init_idx_q <= '0;
            idx_q      <= '0;
            snap_q     <= '0;
            dir_q      <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_PWRUP: begin
                    if (cnt_q == CNT_W'(PWRUP_CYC - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_INIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_INIT: begin
                    if (wr_ack) begin
                        if (init_idx_q == 2'd3) begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            init_idx_q <= init_idx_q + 2'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        snap_q  <= values;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_ADDR;
                    end else if (shift_req) begin
                        dir_q   <= shift_dir;
                        ready_q <= 1'b0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_ADDR: begin
                    if (wr_ack) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (wr_ack) begin
                        idx_q <= idx_d;
                        if (idx_d == IDX_W'(NUM_VALUES)) begin
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end else if ((NUM_VALUES > LINE_LEN) && (idx_d == IDX_W'(LINE_LEN))) begin
                            state_q <= ST_LINE2;
                        end
                    end
                end
                ST_LINE2: begin
                    if (wr_ack) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_SHIFT: begin
                    if (wr_ack) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_PWRUP;
            endcase
        end
    end

    lcd_byte_writer #(
        .EN_CYC  (EN_CYC),
        .CMD_CYC (CMD_CYC),
        .CLR_CYC (CLR_CYC),
        .CNT_W   (CNT_W)
    ) u_writer (
        .clk       (clk),
        .rst       (rst),
        .req       (wr_req),
        .rs        (wr_rs),
        .data      (wr_data),
        .long_wait (wr_long),
        .ack       (wr_ack),
        .lcd_rs    (RS),
        .lcd_e     (E),
        .lcd_db    (DB)
    );

    assign ready = ready_q;
    assign done  = done_q;
    assign RW    = 1'b0;

endmodule

// File: tb/tb_lcd_value_display.sv
// tb/tb_lcd_value_display.sv - directed scoreboard bench for lcd_value_display
module tb_lcd_value_display;

    localparam int NV    = 20;
    localparam int VW    = 5;
    localparam int LL    = 16;
    localparam int PWRUP = 20;
    localparam int EN    = 2;
    localparam int CMD   = 4;
    localparam int CLR   = 10;
    localparam int BYTE_CYC = EN + 2 + CMD;
    localparam int UPD_CYC  = (NV + 1 + ((NV > LL) ? 1 : 0)) * BYTE_CYC + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [NV*VW-1:0]  values = '0;
    logic              shift_req = 1'b0;
    logic              shift_dir = 1'b0;
    logic              ready, done, RS, RW, E;
    logic [7:0]        DB;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_bytes = 0;
    int first_rise = -1;
    int fall_cyc = 0;
    int rel = 0;
    int e_len = 0;
    logic       e_prev = 1'b0;
    logic [8:0] cap;
    logic [8:0] exp_q[$];

    lcd_value_display #(
        .NUM_VALUES (NV),
        .VAL_W      (VW),
        .LINE_LEN   (LL),
        .PWRUP_CYC  (PWRUP),
        .EN_CYC     (EN),
        .CMD_CYC    (CMD),
        .CLR_CYC    (CLR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .values    (values),
        .shift_req (shift_req),
        .shift_dir (shift_dir),
        .ready     (ready),
        .done      (done),
        .RS        (RS),
        .RW        (RW),
        .E         (E),
        .DB        (DB)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] ascii(input int v);
        if (v < 10) return 8'(48 + v);
        return 8'(65 + v - 10);
    endfunction

    // Bus monitor: each E rising edge is one byte, checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            e_prev = 1'b0;
            e_len  = 0;
        end else begin
            if (E && !e_prev) begin
                n_bytes++;
                e_len = 1;
                cap   = {RS, DB};
                if (first_rise < 0) first_rise = cyc;
                check("rw_low", RW, 1'b0);
                check("byte_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("bus_byte", {RS, DB}, exp_q.pop_front());
            end else if (E) begin
                e_len++;
                check("pulse_stable", {RS, DB}, cap);
            end else if (e_prev) begin
                fall_cyc = cyc;
                check("e_width", e_len, EN);
                check("hold_stable", {RS, DB}, cap);
            end
            e_prev = E;
        end
    end

    task automatic push_update();
        exp_q.push_back(9'h080);
        for (int i = 0; i < NV; i++) begin
            if (i == LL && NV > LL) exp_q.push_back(9'h0C0);
            exp_q.push_back({1'b1, ascii(int'(values[i*VW +: VW]))});
        end
    endtask

    task automatic wait_ready(input int bound, output int at);
        int k = 0;
        while (ready !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("ready_timeout", ready, 1'b1);
        at = cyc;
    endtask

    task automatic wait_done(input int bound, output int at);
        int k = 0;
        while (done !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("done_timeout", done, 1'b1);
        at = cyc;
    endtask

    task automatic init_seq(input bit poke);
        int r, base, k;
        @(negedge clk);
        first_rise = -1;
        rel = cyc;
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
        rst = 1'b1;
        if (poke) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            repeat (3) @(negedge clk);
            start = 1'b0;
            base = n_bytes;
            k = 0;
            while (n_bytes < base + 2 && k < 200) begin
                @(negedge clk);
                k++;
            end
            start = 1'b1;
            repeat (2) @(negedge clk);
            start = 1'b0;
        end
        wait_ready(1000, r);
        check("pwrup_delay", first_rise - rel, PWRUP + 2);
        check("clear_gap", r - fall_cyc, CLR);
        check("init_drained", exp_q.size(), 0);
    endtask

    task automatic run_req(input bit do_start, input bit do_shift, input bit dir, input bit scramble);
        int s, d, expd;
        @(negedge clk);
        if (do_start) begin
            push_update();
            expd = UPD_CYC;
        end else begin
            exp_q.push_back(dir ? 9'h01C : 9'h018);
            expd = BYTE_CYC + 1;
        end
        start = do_start;
        shift_req = do_shift;
        shift_dir = dir;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        shift_req = 1'b0;
        shift_dir = ~dir;
        if (scramble) begin
            repeat (40) @(negedge clk);
            for (int i = 0; i < NV; i++) values[i*VW +: VW] = VW'($urandom);
        end
        wait_done(4000, d);
        check("req_duration", d - s, expd);
        check("ready_low_in_done", ready, 1'b0);
        @(negedge clk);
        check("done_single", done, 1'b0);
        check("ready_back", ready, 1'b1);
        check("req_drained", exp_q.size(), 0);
    endtask

    initial begin
        int base, k, nb;
        repeat (3) @(negedge clk);
        check("reset_outputs", {RS, RW, E, DB, ready, done}, 13'h0);

        init_seq(1'b0);

        for (int i = 0; i < NV; i++) values[i*VW +: VW] = VW'(i);
        run_req(1'b1, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < NV; i++) values[i*VW +: VW] = VW'(15);
        run_req(1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) values[i*VW +: VW] = VW'($urandom);
        values[0*VW +: VW] = 5'd31;
        values[1*VW +: VW] = 5'd10;
        values[2*VW +: VW] = 5'd9;
        values[3*VW +: VW] = 5'd0;
        run_req(1'b1, 1'b0, 1'b0, 1'b0);

        run_req(1'b0, 1'b1, 1'b1, 1'b0);
        run_req(1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) values[i*VW +: VW] = VW'(1);
        run_req(1'b1, 1'b1, 1'b1, 1'b0);
        nb = n_bytes;
        repeat (15) @(negedge clk);
        check("no_shift_after_update", n_bytes, nb);

        for (int i = 0; i < NV; i++) values[i*VW +: VW] = VW'(i);
        @(negedge clk);
        push_update();
        base = n_bytes;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (n_bytes < base + 4 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("third_data_rise", n_bytes - base, 4);
        check("e_high_pre_rst", E, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("rst_E", E, 1'b0);
        check("rst_DB", DB, 8'h00);
        check("rst_RS", RS, 1'b0);
        check("rst_ready_done", {ready, done}, 2'b00);
        exp_q.delete();
        repeat (3) @(negedge clk);

        init_seq(1'b1);
        nb = n_bytes;
        repeat (20) @(negedge clk);
        check("no_spurious_update", n_bytes, nb);
        check("ready_held", ready, 1'b1);

        for (int i = 0; i < NV; i++) values[i*VW +: VW] = VW'(15);
        run_req(1'b1, 1'b0, 1'b0, 1'b0);
        check("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_value_display.md
Name: lcd_value_display

Overview:
- Parametrised HD44780-class character-LCD driver; successor to the fixed 10-value LCD controller in the BNN hardware LCD_Screen area.
- Runs the power-up init sequence autonomously, then on request writes NUM_VALUES small values as ASCII characters, wrapping from line 1 to line 2.
- Also issues display-shift commands on request.
- Write-only 8-bit bus with cycle-count timing; the busy flag is never read.

Parameters:
- NUM_VALUES, 10, number of values/characters written per update (1..32).
- VAL_W, 5, width of each value (1..5).
- LINE_LEN, 16, characters per display line.
- PWRUP_CYC, 750000, cycles waited after reset before the first command.
- EN_CYC, 12, cycles E is held high per byte.
- CMD_CYC, 2000, settle cycles after any byte other than clear.
- CLR_CYC, 82000, settle cycles after clear (0x01).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  request display update; accepted only when ready=1.
- values  in  NUM_VALUES*VAL_W  value i at bits [i*VAL_W +: VAL_W]; character i = value i.
- shift_req  in  1  request display shift; accepted only when ready=1 and start=0.
- shift_dir  in  1  0 = shift left (0x18), 1 = shift right (0x1C); sampled with shift_req.
- ready  out  1  idle, init complete, requests accepted.
- done  out  1  one-cycle pulse when an update or shift completes.
- RS  out  1  LCD register select (0 = command, 1 = data).
- RW  out  1  LCD read/write; tied low (0 = write).
- E  out  1  LCD enable strobe.
- DB  out  8  LCD data bus.

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - Drives RS=0, RW=0, E=0, DB=0x00, ready=0, done=0.
  - Returns to PWRUP with all counters cleared.
  - Reset mid-byte or mid-update aborts it immediately; the full init re-runs after release.
- Top FSM states: PWRUP → INIT → IDLE → ADDR → DATA → (LINE2 → DATA) → FIN → IDLE. IDLE → SHIFT → FIN.
- PWRUP: count PWRUP_CYC cycles, then go to INIT.
- INIT issues, in order:
  - 0x38 (8-bit, 2 lines, 5x8)
  - 0x0C (display on, cursor off)
  - 0x06 (increment, no shift)
  - 0x01 (clear; uses CLR_CYC)
  - Then go to IDLE.
- IDLE: ready=1.
  - start has priority over shift_req.
  - On start: snapshot values into an internal register. Later changes on values do not affect this update. Go to ADDR.
  - On shift_req (start=0): latch shift_dir, go to SHIFT.
- ADDR: command 0x80 (DDRAM address 0).
- DATA: write characters for index 0..NUM_VALUES-1 with RS=1.
  - Character map: v<10 → 0x30+v; v≥10 → 0x41+(v-10). Values 10..31 map to 'A'..'V'.
- LINE2: when the index reaches LINE_LEN and NUM_VALUES>LINE_LEN, issue command 0xC0 before character LINE_LEN.
- SHIFT: single command, 0x18 or 0x1C.
- FIN: done=1 for exactly one cycle, ready=0 that cycle; next cycle IDLE.
- Requests while ready=0 are ignored, not queued. start and shift_req are level-sampled only in IDLE.
- Byte transaction phases (sub-module):
  - SETUP: 1 cycle, E=0, RS/DB valid.
  - PULSE: EN_CYC cycles, E=1.
  - HOLD: 1 cycle, E=0.
  - WAIT: CMD_CYC cycles, or CLR_CYC for 0x01.
  - Occupancy is EN_CYC+2+wait cycles.
  - RS/DB stay stable from SETUP through HOLD.
  - E is glitch-free and registered.
- Outputs: all registered. RW is constant 0.
- Counter width: $clog2 of the largest timing parameter +1. Wrap-around is impossible by construction.
- Update duration, NUM_VALUES ≤ LINE_LEN: (NUM_VALUES+1)*(EN_CYC+2+CMD_CYC) cycles + FIN. Add one extra byte time when line 2 is used.

Decomposition:
- Package lcd_pkg contains:
  - command constants: CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY=0x06, CMD_CLEAR=0x01, CMD_LINE1=0x80, CMD_LINE2=0xC0, CMD_SHIFT_L=0x18, CMD_SHIFT_R=0x1C;
  - top-state enum;
  - function val_to_char(logic [4:0]) returning logic [7:0].
- Sub-module lcd_byte_writer: req/rs/data/long_wait in, ack out. It owns the SETUP/PULSE/HOLD/WAIT FSM and drives RS/E/DB.

Test Plan (EN_CYC=2, CMD_CYC=4, CLR_CYC=10, PWRUP_CYC=20 unless noted):
- Reset release, no requests → after 20 cycles, bytes 0x38, 0x0C, 0x06 (RS=0), then 0x01; each E pulse is 2 cycles. Gap after 0x01 is 10 cycles; ready rises only after that.
- start with values {0..9} → 0x80 (RS=0), then 0x30..0x39 (RS=1); one-cycle done; ready=1 again. Changing values mid-update does not alter the bytes.
- NUM_VALUES=20, LINE_LEN=16, all values=15 → 0x80, sixteen 0x46, 0xC0, four 0x46.
- shift_req with shift_dir=1 in IDLE → single 0x1C with RS=0, then done. start and shift_req together → update only, no shift byte.
- Reset asserted during PULSE of the 3rd data byte → E=0, DB=0x00, RS=0 immediately; init sequence replays after release. start pulses during init → ignored (no 0x80 emitted).
- Value 31 → 0x56 ('V'). Value 10 → 0x41 ('A'). RW stays 0 throughout all scenarios.
